// File: rtl/alu_mod32_seq_pkg.sv
// Shared constants for the sequential modulo unit: width defaults and FSM encodings.
package alu_mod32_seq_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  // state | meaning
  // IDLE  | waiting for start; outputs hold the last op's results
  // RUN   | one restoring shift-subtract iteration per cycle
  // DONE  | single-cycle done pulse, then back to IDLE
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/alu_mod32_seq_ctrl.sv
// Sequencer for the modulo unit: FSM plus iteration counter, emitting
// load / shift / finish strobes for the datapath in the top level.
module alu_mod32_seq_ctrl
  import alu_mod32_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic start_i,
  input  logic b_zero_i,
  output logic load_o,
  output logic shift_o,
  output logic finish_o,
  output logic busy_o,
  output logic done_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state and counter logic; a zero divisor skips RUN entirely.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          cnt_d   = '0;
          state_d = b_zero_i ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign load_o   = (state_q == ST_IDLE) && start_i;
  assign shift_o  = (state_q == ST_RUN);
  assign finish_o = shift_o && (cnt_q == LAST_CNT);
  assign busy_o   = (state_q != ST_IDLE);
  assign done_o   = (state_q == ST_DONE);

endmodule

// File: rtl/alu_mod32_seq.sv
// Sequential unsigned modulo/divide unit (restoring shift-subtract, one
// quotient bit per cycle). Feeds the ALU result mux on the MOD opcode.
module alu_mod32_seq
  import alu_mod32_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] quotient,
  output logic             div_by_zero
);

  logic load, shift, finish;
  logic b_zero;

  // The partial remainder is always < D after each step, so only its low
  // WIDTH bits need storing; the compare itself runs at WIDTH+1 bits.
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] res_q, quo_q;
  logic             dbz_q;
  logic [WIDTH:0]   r_shift, t;

  assign b_zero = (b == '0);

  alu_mod32_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ctrl (
    .clk_i    (clk),
    .reset_i  (reset),
    .start_i  (start),
    .b_zero_i (b_zero),
    .load_o   (load),
    .shift_o  (shift),
    .finish_o (finish),
    .busy_o   (busy),
    .done_o   (done)
  );

  // One restoring iteration: trial-subtract D from the shifted remainder.
  always_comb begin
    r_shift = {1'b0, r_q[WIDTH-1:0], q_q[WIDTH-1]} >> 0;
    r_shift = {r_q, q_q[WIDTH-1]};
    t       = r_shift - {1'b0, d_q};
    if (!t[WIDTH]) begin
      r_d = t[WIDTH-1:0];
      q_d = {q_q[WIDTH-2:0], 1'b1};
    end else begin
      r_d = r_shift[WIDTH-1:0];
      q_d = {q_q[WIDTH-2:0], 1'b0};
    end
  end

  // Datapath registers; results hold until the next accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q   <= '0;
      q_q   <= '0;
      d_q   <= '0;
      res_q <= '0;
      quo_q <= '0;
      dbz_q <= 1'b0;
    end else if (load) begin
      r_q   <= '0;
      q_q   <= a;
      d_q   <= b;
      dbz_q <= b_zero;
      if (b_zero) begin
        res_q <= a;
        quo_q <= '1;
      end
    end else if (shift) begin
      r_q <= r_d;
      q_q <= q_d;
      if (finish) begin
        res_q <= r_d;
        quo_q <= q_d;
      end
    end
  end

  assign result      = res_q;
  assign quotient    = quo_q;
  assign div_by_zero = dbz_q;

endmodule
